// File: rtl/ram_responder.sv
// Single-port-style 64-bit RAM with byte-lane writes and a fixed-latency,
// one-outstanding read responder (IDLE/WAIT/RESP).
module ram_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RD_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_in,
  input  logic [63:0] raddr_in,
  input  logic        r_ena_in,
  input  logic [63:0] waddr_in,
  input  logic [63:0] wdata_in,
  input  logic        w_ena_in,
  input  logic [7:0]  sel_in,
  output logic [63:0] rdata_out,
  output logic        r_valid_out,
  output logic        busy_out
);
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  logic [63:0] mem [WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] raddr_q, raddr_d;
  logic [63:0] rdata_q, rdata_d;
  logic        r_valid_q, r_valid_d;

  logic [63:0]           woff, roff, rd_addr, rd_word;
  logic                  w_in_rng, r_in_rng, w_fire;
  logic [DEPTH_LOG2-1:0] widx, ridx;

  // In IDLE the word is addressed straight from the port so a latency-1
  // read can be sampled on its own acceptance edge.
  assign rd_addr  = (state_q == IDLE) ? raddr_in : raddr_q;

  // Word offsets; the unsigned compare also rejects addresses below BASE_ADDR
  // because the subtraction wraps to a huge value.
  assign woff     = (waddr_in - BASE_ADDR) >> 3;
  assign roff     = (rd_addr  - BASE_ADDR) >> 3;
  assign w_in_rng = woff < 64'(WORDS);
  assign r_in_rng = roff < 64'(WORDS);
  assign widx     = woff[DEPTH_LOG2-1:0];
  assign ridx     = roff[DEPTH_LOG2-1:0];
  assign w_fire   = ce_in & w_ena_in & w_in_rng;

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 8; b++) begin
        if (sel_in[b]) mem[widx][8*b +: 8] <= wdata_in[8*b +: 8];
      end
    end
  end

  // Forward a write landing on the sampling edge so the read sees post-write data.
  always_comb begin
    rd_word = '0;
    if (r_in_rng) begin
      rd_word = mem[ridx];
      if (w_fire && (widx == ridx)) begin
        for (int b = 0; b < 8; b++) begin
          if (sel_in[b]) rd_word[8*b +: 8] = wdata_in[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    r_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce_in && r_ena_in) begin
          raddr_d = raddr_in;
          if (RD_LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = 4'(RD_LATENCY - 1);
          end else begin
            state_d   = RESP;
            r_valid_d = 1'b1;
            rdata_d   = rd_word;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          cnt_d     = 4'd0;
          r_valid_d = 1'b1;
          rdata_d   = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      raddr_q   <= 64'h0;
      rdata_q   <= 64'h0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign rdata_out   = rdata_q;
  assign r_valid_out = r_valid_q;
  assign busy_out    = (state_q != IDLE);

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: latency-2 and latency-1 instances on shared stimulus,
// checked every cycle against a timing/memory model plus directed literals.
module tb_ram_responder;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          NW   = 1024;
  localparam int          LAT [2] = '{2, 1};

  logic        clk, rst, ce_in, r_ena_in, w_ena_in;
  logic [63:0] raddr_in, waddr_in, wdata_in;
  logic [7:0]  sel_in;
  logic [63:0] rdata [2];
  logic        rv [2];
  logic        busy [2];

  int n_chk = 0;
  int n_fail = 0;
  bit run_chk = 0;

  ram_responder #(.DEPTH_LOG2(10), .RD_LATENCY(2), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .rst(rst), .ce_in(ce_in), .raddr_in(raddr_in), .r_ena_in(r_ena_in),
    .waddr_in(waddr_in), .wdata_in(wdata_in), .w_ena_in(w_ena_in), .sel_in(sel_in),
    .rdata_out(rdata[0]), .r_valid_out(rv[0]), .busy_out(busy[0]));

  ram_responder #(.DEPTH_LOG2(10), .RD_LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst(rst), .ce_in(ce_in), .raddr_in(raddr_in), .r_ena_in(r_ena_in),
    .waddr_in(waddr_in), .wdata_in(wdata_in), .w_ena_in(w_ena_in), .sel_in(sel_in),
    .rdata_out(rdata[1]), .r_valid_out(rv[1]), .busy_out(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: flat word array plus, per instance, the one request in flight.
  bit [63:0] mdl [NW];
  bit        pend [2];
  longint    pn [2];
  bit [63:0] pa [2];
  bit [63:0] exp_rd [2];
  bit        exp_rv [2];
  bit        exp_busy [2];
  longint    e = 0;

  function automatic bit in_rng(input bit [63:0] a);
    return ((a - BASE) >> 3) < 64'(NW);
  endfunction

  function automatic int widx(input bit [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] = 0; exp_rd[k] = 0; exp_rv[k] = 0; exp_busy[k] = 0;
      end
    end else begin
      e++;
      if (ce_in && w_ena_in && in_rng(waddr_in))
        for (int b = 0; b < 8; b++)
          if (sel_in[b]) mdl[widx(waddr_in)][8*b +: 8] = wdata_in[8*b +: 8];
      for (int k = 0; k < 2; k++) begin
        // A request is served over edges N..N+LAT; the next can land at N+LAT+1.
        if (pend[k] && e > pn[k] + LAT[k]) pend[k] = 0;
        if (!pend[k] && ce_in && r_ena_in) begin
          pend[k] = 1; pn[k] = e; pa[k] = raddr_in;
        end
        exp_rv[k]   = pend[k] && (e == pn[k] + LAT[k] - 1);
        exp_busy[k] = pend[k] && (e <  pn[k] + LAT[k]);
        if (exp_rv[k]) exp_rd[k] = in_rng(pa[k]) ? mdl[widx(pa[k])] : 64'h0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (run_chk && rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model r_valid[%0d]", k), {63'h0, rv[k]},   {63'h0, exp_rv[k]});
        chk($sformatf("model busy[%0d]", k),    {63'h0, busy[k]}, {63'h0, exp_busy[k]});
        chk($sformatf("model rdata[%0d]", k),   rdata[k],         exp_rd[k]);
      end
    end
  end

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    waddr_in = a; wdata_in = d; sel_in = s; w_ena_in = 1'b1;
    @(negedge clk);
    w_ena_in = 1'b0;
  endtask

  // Read from idle; both instances accept on the same edge.
  task automatic rd(input logic [63:0] a, input logic [63:0] exp, input string nm);
    raddr_in = a; r_ena_in = 1'b1;
    @(negedge clk);
    r_ena_in = 1'b0;
    chk({nm, " busy0 in wait"}, {63'h0, busy[0]}, 64'h1);
    chk({nm, " rv0 early"},     {63'h0, rv[0]},   64'h0);
    chk({nm, " rv1"},           {63'h0, rv[1]},   64'h1);
    chk({nm, " rdata1"},        rdata[1],         exp);
    @(negedge clk);
    chk({nm, " rv0"},           {63'h0, rv[0]},   64'h1);
    chk({nm, " busy0 in resp"}, {63'h0, busy[0]}, 64'h1);
    chk({nm, " rdata0"},        rdata[0],         exp);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] mask;
    rst = 1'b1; ce_in = 1'b0; r_ena_in = 1'b0; w_ena_in = 1'b0;
    raddr_in = '0; waddr_in = '0; wdata_in = '0; sel_in = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset rv0",    {63'h0, rv[0]},   64'h0);
    chk("reset busy0",  {63'h0, busy[0]}, 64'h0);
    chk("reset rdata0", rdata[0],         64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1; ce_in = 1'b1; run_chk = 1'b1;

    // Full, partial and empty byte-lane writes
    wr(BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF);
    rd(BASE + 64'h10, 64'h1122_3344_5566_7788, "full write");
    wr(BASE + 64'h10, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
    rd(BASE + 64'h10, 64'h1122_3344_BBBB_BBBB, "partial write");
    wr(BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rd(BASE + 64'h10, 64'h1122_3344_BBBB_BBBB, "sel zero");

    // Range boundaries; out-of-range writes must not alias onto real words
    wr(BASE,                   64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    wr(BASE + 64'h1FF8,        64'h0123_4567_89AB_CDEF, 8'hFF);
    wr(64'h0000_0000_7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(BASE + 64'h2000,        64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
    rd(64'h0000_0000_7FFF_FFF8, 64'h0, "below base");
    rd(BASE + 64'h2000,        64'h0, "past end");
    rd(BASE,                   64'hDEAD_BEEF_0BAD_F00D, "word0");
    rd(BASE + 64'h1FF8,        64'h0123_4567_89AB_CDEF, "last word");
    rd(BASE + 64'h13,          64'h1122_3344_BBBB_BBBB, "low bits ignored");

    // ce_in low masks both requests
    ce_in = 1'b0; r_ena_in = 1'b1; w_ena_in = 1'b1;
    raddr_in = BASE + 64'h10; waddr_in = BASE + 64'h10; wdata_in = '0; sel_in = 8'hFF;
    @(negedge clk);
    chk("ce low busy0", {63'h0, busy[0]}, 64'h0);
    chk("ce low rv1",   {63'h0, rv[1]},   64'h0);
    ce_in = 1'b1; r_ena_in = 1'b0; w_ena_in = 1'b0;
    rd(BASE + 64'h10, 64'h1122_3344_BBBB_BBBB, "ce low no write");

    // Held read for ten edges: latency-2 pulses land at cycles 2, 5, 8
    raddr_in = BASE; r_ena_in = 1'b1; mask = '0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      mask[j] = rv[0];
    end
    r_ena_in = 1'b0;
    chk("held read pulses", {48'h0, mask}, 64'h0124);
    repeat (4) @(negedge clk);

    // Write to the pending word while the read waits
    raddr_in = BASE + 64'h10; r_ena_in = 1'b1;
    @(negedge clk);
    r_ena_in = 1'b0;
    waddr_in = BASE + 64'h10; wdata_in = 64'h5555_6666_7777_8888; sel_in = 8'hFF; w_ena_in = 1'b1;
    @(negedge clk);
    w_ena_in = 1'b0;
    chk("write in wait rv0",    {63'h0, rv[0]}, 64'h1);
    chk("write in wait rdata0", rdata[0],       64'h5555_6666_7777_8888);
    @(negedge clk);

    // Read and write on the same idle edge
    raddr_in = BASE + 64'h8; r_ena_in = 1'b1;
    waddr_in = BASE + 64'h8; wdata_in = 64'hCAFE_0000_1234_5678; sel_in = 8'hFF; w_ena_in = 1'b1;
    @(negedge clk);
    r_ena_in = 1'b0; w_ena_in = 1'b0;
    chk("same edge rdata1", rdata[1], 64'hCAFE_0000_1234_5678);
    @(negedge clk);
    chk("same edge rdata0", rdata[0], 64'hCAFE_0000_1234_5678);
    @(negedge clk);

    // Reset in the middle of a latency-2 read
    raddr_in = BASE + 64'h1FF8; r_ena_in = 1'b1;
    @(negedge clk);
    r_ena_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid reset busy0",  {63'h0, busy[0]}, 64'h0);
    chk("mid reset rv0",    {63'h0, rv[0]},   64'h0);
    chk("mid reset rdata0", rdata[0],         64'h0);
    chk("mid reset rv1",    {63'h0, rv[1]},   64'h0);
    chk("mid reset rdata1", rdata[1],         64'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("aborted read rv0", {63'h0, rv[0]}, 64'h0);
    end
    rd(BASE,          64'hDEAD_BEEF_0BAD_F00D, "retained word0");
    rd(BASE + 64'h10, 64'h5555_6666_7777_8888, "retained word2");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
